fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of `decode_unit`. It owns the program counter, issues word reads to a fixed-latency instruction memory, and buffers the returned words in a small in-order queue. It presents one instruction per cycle to decode, tagged with its PC. Decode-side `stall` holds the head, and `is_branch_taken` flushes the stage and redirects it.

## Interface
- `IQ_DEPTH`, 4: instruction queue entries; power of two, 2..16.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  decode cannot accept; hold current head.
- `is_branch_taken`  in  1  redirect request, one-cycle pulse.
- `branch_target`  in  16  new PC, sampled when `is_branch_taken`=1.
- `imem_req`  out  1  read request this cycle.
- `imem_addr`  out  16  word address of request.
- `imem_rdata`  in  16  read data, valid with `imem_valid`.
- `imem_valid`  in  1  asserted exactly one cycle after an accepted `imem_req`.
- `instr`  out  16  head instruction; 16'h0000 (NOP) when empty.
- `instr_pc`  out  16  PC of `instr`; 16'h0000 when empty.
- `instr_valid`  out  1  head is a real instruction.

## Operation
- State:
  - `pc` (next address to request), 16 bits.
  - Queue of {instr, pc} with head/tail pointers and an occupancy count.
  - One in-flight flag with a recorded request PC.
  - One `epoch` bit.
- Addressing is word-based: `pc` increments by 1 per request and wraps 16'hFFFF -> 16'h0000.
- Request rule:
  - `imem_req`=1 iff not in reset, `is_branch_taken`=0, and `count + inflight < IQ_DEPTH`.
  - `imem_addr`=`pc`. `pc` advances on every issued request.
- Response rule:
  - When `imem_valid`=1, the in-flight flag is set, and its epoch equals the current `epoch`, push {`imem_rdata`, recorded PC} at the tail.
  - A response with mismatched epoch, or with no in-flight request, is discarded.
- Pop rule: when `instr_valid`=1 and `stall`=0, the head is consumed at the clock edge.
- Push and pop in the same cycle are legal at any occupancy. The credit rule makes overflow impossible.
- Redirect: when `is_branch_taken`=1 at an edge:
  - Queue is emptied.
  - `pc` <= `branch_target`.
  - `epoch` toggles, so any response arriving next cycle is dropped.
  - No request is issued in the redirect cycle.
- Priority: reset > `is_branch_taken` > `stall`. A redirect during stall still flushes.
- Outputs `instr`, `instr_pc`, and `instr_valid` are driven from the queue head. When the queue is empty: `instr`=16'h0000, `instr_pc`=16'h0000, `instr_valid`=0.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, queue empty, inflight=0, `epoch`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instr`=16'h0000, `instr_pc`=16'h0000, `instr_valid`=0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. A response arriving after release is ignored because inflight=0.
- First request is issued in the first cycle after `reset` deasserts (cycle 0).
- Latency from request to visible head:
  - Request in cycle t; data arrives in cycle t+1 and is written at the end of t+1.
  - `instr_valid`=1 in cycle t+2 when the queue was empty.
- Steady state with `stall`=0 is one instruction per cycle. The queue holds 1 entry and 1 request is in flight.
- Redirect at the edge ending cycle b:
  - `imem_req`=0 in cycle b.
  - `imem_addr`=`branch_target`, `imem_req`=1 in cycle b+1.
  - Target instruction is valid in cycle b+3.
  - `instr_valid`=0 in cycles b+1 and b+2.
- Full queue under stall: `imem_req` drops once `count + inflight` = `IQ_DEPTH`. Requests resume in the cycle after the first pop.

## Configuration
- `FETCH_PERF_CNT_EN` defined adds three 16-bit saturating output ports, all reset to 0:
  - `perf_fetched`: pushes.
  - `perf_stall_cycles`: cycles with `stall`=1 and `instr_valid`=1.
  - `perf_flushes`: `is_branch_taken` edges.
- `FETCH_PERF_CNT_EN` undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset then run, memory[i]=16'h1000+i, `stall`=0:
  - `imem_addr`=0,1,2,... from cycle 0.
  - `instr`=16'h1000 with `instr_pc`=0 in cycle 2, then 16'h1001, 16'h1002 each cycle.
- `stall`=1 for 6 cycles starting cycle 3:
  - `instr` holds 16'h1001.
  - `imem_req`=0 after the queue fills with 4 entries.
  - On release, 16'h1001..16'h1006 appear in order with no gap or duplicate.
- `is_branch_taken`=1 with `branch_target`=16'h0040 while a request is in flight:
  - Queue is flushed and the stale response is dropped.
  - `imem_addr`=16'h0040 next cycle; `instr_pc`=16'h0040 three cycles after the redirect.
- Redirect and `stall`=1 in the same cycle: flush wins; `instr_valid`=0 next cycle.
- `reset` asserted mid-stream with 3 entries queued:
  - Outputs go to reset values immediately.
  - After release, fetch restarts at `RESET_PC`.
- PC wrap: `branch_target`=16'hFFFF gives `instr_pc` 16'hFFFF then 16'h0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues fixed-latency imem reads and queues returned words for decode.
// Optional build macro FETCH_PERF_CNT_EN adds saturating perf counters (pushes, stalled-valid cycles, flushes).
module fetch_unit #(
  parameter int unsigned IQ_DEPTH = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        is_branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic        instr_valid,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_stall_cycles,
  output logic [15:0] perf_flushes
`else
  output logic        instr_valid
`endif
);

  localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(IQ_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [15:0]      pc_r;
  logic             epoch_r;
  logic             inflight_r;
  logic [15:0]      inflight_pc_r;
  logic             inflight_epoch_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [15:0]      q_instr_r [IQ_DEPTH];
  logic [15:0]      q_pc_r    [IQ_DEPTH];

  logic [CNT_W-1:0] credit_s;
  logic             push_s;
  logic             pop_s;
  logic             head_valid_s;

  // Request credit: queued entries plus the outstanding read must leave room for the response.
  always_comb begin
    credit_s = count_r + CNT_W'(inflight_r);
    if (!reset) begin
      imem_req = 1'b0;
    end else if (is_branch_taken) begin
      imem_req = 1'b0;
    end else if (credit_s < DEPTH_C) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
  end

  assign imem_addr = pc_r;

  // Accept a response only if it belongs to the current epoch's outstanding request; pop on an unstalled head.
  always_comb begin
    head_valid_s = (count_r != CNT_ZERO);
    push_s       = imem_valid && inflight_r && (inflight_epoch_r == epoch_r);
    if (head_valid_s && !stall) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Head presentation: an empty queue shows a NOP tagged with PC zero.
  always_comb begin
    instr       = 16'h0000;
    instr_pc    = 16'h0000;
    instr_valid = 1'b0;
    if (head_valid_s) begin
      instr       = q_instr_r[head_r];
      instr_pc    = q_pc_r[head_r];
      instr_valid = 1'b1;
    end else begin
      instr       = 16'h0000;
      instr_pc    = 16'h0000;
      instr_valid = 1'b0;
    end
  end

  // PC, in-flight tracking, epoch and queue pointers; a redirect flushes and retargets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r             <= RESET_PC;
      epoch_r          <= 1'b0;
      inflight_r       <= 1'b0;
      inflight_pc_r    <= 16'h0000;
      inflight_epoch_r <= 1'b0;
      head_r           <= PTR_ZERO;
      tail_r           <= PTR_ZERO;
      count_r          <= CNT_ZERO;
    end else if (is_branch_taken) begin
      // The toggled epoch fences off any response belonging to the old path.
      pc_r       <= branch_target;
      epoch_r    <= ~epoch_r;
      inflight_r <= 1'b0;
      head_r     <= PTR_ZERO;
      tail_r     <= PTR_ZERO;
      count_r    <= CNT_ZERO;
    end else begin
      if (imem_req) begin
        pc_r             <= pc_r + 16'd1;
        inflight_r       <= 1'b1;
        inflight_pc_r    <= pc_r;
        inflight_epoch_r <= epoch_r;
      end else if (imem_valid) begin
        inflight_r <= 1'b0;
      end else begin
        inflight_r <= inflight_r;
      end
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage written at the tail with the returned word and its request PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
        q_instr_r[i] <= 16'h0000;
        q_pc_r[i]    <= 16'h0000;
      end
    end else if (push_s && !is_branch_taken) begin
      q_instr_r[tail_r] <= imem_rdata;
      q_pc_r[tail_r]    <= inflight_pc_r;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched_r;
  logic [15:0] perf_stall_cycles_r;
  logic [15:0] perf_flushes_r;

  // Saturating event counters; pushes discarded by a same-cycle flush are not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_r      <= 16'h0000;
      perf_stall_cycles_r <= 16'h0000;
      perf_flushes_r      <= 16'h0000;
    end else begin
      if (push_s && !is_branch_taken && (perf_fetched_r != 16'hFFFF)) begin
        perf_fetched_r <= perf_fetched_r + 16'd1;
      end
      if (stall && head_valid_s && (perf_stall_cycles_r != 16'hFFFF)) begin
        perf_stall_cycles_r <= perf_stall_cycles_r + 16'd1;
      end
      if (is_branch_taken && (perf_flushes_r != 16'hFFFF)) begin
        perf_flushes_r <= perf_flushes_r + 16'd1;
      end
    end
  end

  assign perf_fetched      = perf_fetched_r;
  assign perf_stall_cycles = perf_stall_cycles_r;
  assign perf_flushes      = perf_flushes_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: 1-cycle memory model, queue-based reference model, directed and random scenarios.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [15:0] RPC   = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        is_branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall_cycles;
  logic [15:0] perf_flushes;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.IQ_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .is_branch_taken(is_branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instr(instr),
    .instr_pc(instr_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched), .perf_stall_cycles(perf_stall_cycles),
    .perf_flushes(perf_flushes),
`endif
    .instr_valid(instr_valid)
  );

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  // Memory answers exactly one cycle after a request; inject forces a stray response.
  logic        mem_valid_r = 1'b0;
  logic [15:0] mem_rdata_r = 16'h0000;
  logic        inject = 1'b0;
  always @(posedge clk) begin
    mem_valid_r <= imem_req;
    mem_rdata_r <= memf(imem_addr);
  end
  assign imem_valid = mem_valid_r | inject;
  assign imem_rdata = inject ? 16'hBAD0 : mem_rdata_r;

  // Reference model: queue of (instr, pc), next PC, and whether a read is outstanding.
  logic [15:0] q_ins[$];
  logic [15:0] q_pc[$];
  logic [15:0] m_pc;
  logic [15:0] m_infl_pc;
  bit          m_infl;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        obs_valid, obs_req;
  logic [15:0] obs_instr, obs_pc, obs_addr;

  task automatic model_reset();
    q_ins.delete();
    q_pc.delete();
    m_pc = RPC;
    m_infl = 1'b0;
    m_infl_pc = 16'h0000;
  endtask

  // One clock cycle: drive inputs, compare against the model mid-cycle, then advance the model.
  task automatic cycle(input logic st, input logic br, input logic [15:0] tgt, input logic inj);
    logic ev, er, resp;
    logic [15:0] ei, ep;
    stall = st; is_branch_taken = br; branch_target = tgt; inject = inj;
    @(negedge clk);
    ev = (q_ins.size() != 0);
    ei = ev ? q_ins[0] : 16'h0000;
    ep = ev ? q_pc[0] : 16'h0000;
    er = !br && ((q_ins.size() + int'(m_infl)) < DEPTH);
    obs_valid = instr_valid; obs_instr = instr; obs_pc = instr_pc;
    obs_req = imem_req; obs_addr = imem_addr;
    n_checks++;
    if (obs_valid !== ev) begin n_fail++; $display("FAIL model_valid c%0d: got %b expected %b", cyc, obs_valid, ev); end
    n_checks++;
    if (obs_instr !== ei) begin n_fail++; $display("FAIL model_instr c%0d: got %h expected %h", cyc, obs_instr, ei); end
    n_checks++;
    if (obs_pc !== ep) begin n_fail++; $display("FAIL model_instr_pc c%0d: got %h expected %h", cyc, obs_pc, ep); end
    n_checks++;
    if (obs_req !== er) begin n_fail++; $display("FAIL model_req c%0d: got %b expected %b", cyc, obs_req, er); end
    n_checks++;
    if (obs_addr !== m_pc) begin n_fail++; $display("FAIL model_addr c%0d: got %h expected %h", cyc, obs_addr, m_pc); end
    resp = imem_valid;
    @(posedge clk);
    if (br) begin
      q_ins.delete();
      q_pc.delete();
      m_pc = tgt;
    end else begin
      if (ev && !st) begin
        void'(q_ins.pop_front());
        void'(q_pc.pop_front());
      end
      if (resp && m_infl) begin
        q_ins.push_back(memf(m_infl_pc));
        q_pc.push_back(m_infl_pc);
      end
      if (er) begin
        m_infl_pc = m_pc;
        m_pc = m_pc + 16'd1;
      end
    end
    m_infl = er;
    #1;
    inject = 1'b0;
    is_branch_taken = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_checks++;
    if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h expected 0000", instr); end
    n_checks++;
    if (instr_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_instr_pc: got %h expected 0000", instr_pc); end
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_checks++;
    if (imem_addr !== RPC) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RPC); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_run();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 16'h0000, 1'b0);
      n_checks++;
      if (obs_addr !== 16'(i) || obs_req !== 1'b1) begin
        n_fail++; $display("FAIL run_addr c%0d: got req=%b addr=%h expected req=1 addr=%h", i, obs_req, obs_addr, 16'(i));
      end
      if (i >= 2) begin
        n_checks++;
        if (obs_instr !== 16'h1000 + 16'(i - 2) || obs_pc !== 16'(i - 2) || obs_valid !== 1'b1) begin
          n_fail++; $display("FAIL run_head c%0d: got %h@%h v=%b expected %h@%h", i, obs_instr, obs_pc, obs_valid,
                             16'h1000 + 16'(i - 2), 16'(i - 2));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cycle((i >= 3 && i <= 8) ? 1'b1 : 1'b0, 1'b0, 16'h0000, 1'b0);
      if (i >= 3 && i <= 9) begin
        n_checks++;
        if (obs_instr !== 16'h1001) begin n_fail++; $display("FAIL stall_hold c%0d: got %h expected 1001", i, obs_instr); end
      end
      if (i >= 5 && i <= 9) begin
        n_checks++;
        if (obs_req !== 1'b0) begin n_fail++; $display("FAIL stall_full_req c%0d: got %b expected 0", i, obs_req); end
      end
      if (i == 10) begin
        n_checks++;
        if (obs_req !== 1'b1) begin n_fail++; $display("FAIL stall_resume_req c%0d: got %b expected 1", i, obs_req); end
      end
      if (i >= 9 && i <= 14) begin
        n_checks++;
        if (obs_instr !== 16'h1001 + 16'(i - 9) || obs_valid !== 1'b1) begin
          n_fail++; $display("FAIL stall_release c%0d: got %h v=%b expected %h", i, obs_instr, obs_valid, 16'h1001 + 16'(i - 9));
        end
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (4) cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    cycle(1'b0, 1'b1, 16'h0040, 1'b0);
    n_checks++;
    if (obs_req !== 1'b0) begin n_fail++; $display("FAIL branch_req_b: got %b expected 0", obs_req); end
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== 16'h0040 || obs_valid !== 1'b0) begin
      n_fail++; $display("FAIL branch_b1: got req=%b addr=%h v=%b expected 1 0040 0", obs_req, obs_addr, obs_valid);
    end
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL branch_b2_valid: got %b expected 0", obs_valid); end
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b1 || obs_pc !== 16'h0040 || obs_instr !== 16'h1040) begin
      n_fail++; $display("FAIL branch_b3_head: got %h@%h v=%b expected 1040@0040", obs_instr, obs_pc, obs_valid);
    end
  endtask

  task automatic test_branch_stall();
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    cycle(1'b1, 1'b1, 16'h0080, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL branch_stall_flush: got %b expected 0", obs_valid); end
    repeat (2) cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (obs_pc !== 16'h0080 || obs_valid !== 1'b1) begin
      n_fail++; $display("FAIL branch_stall_target: got %h v=%b expected 0080", obs_pc, obs_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (q_ins.size() != 3 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_fill: got v=%b model entries %0d expected 3", instr_valid, q_ins.size());
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc !== 16'h0000 || imem_req !== 1'b0 || imem_addr !== RPC) begin
      n_fail++; $display("FAIL reset_mid_outputs: got v=%b %h@%h req=%b addr=%h expected 0 0000@0000 0 %h",
                         instr_valid, instr, instr_pc, imem_req, imem_addr, RPC);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    cyc = 0;
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    n_checks++;
    if (obs_addr !== RPC || obs_req !== 1'b1) begin n_fail++; $display("FAIL reset_mid_restart: got %h req=%b expected %h", obs_addr, obs_req, RPC); end
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stray: got v=%b expected 0", obs_valid); end
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (obs_instr !== 16'h1000 || obs_pc !== RPC) begin n_fail++; $display("FAIL reset_mid_head: got %h@%h expected 1000@%h", obs_instr, obs_pc, RPC); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (2) cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (obs_pc !== 16'hFFFF || obs_instr !== 16'h0FFF) begin n_fail++; $display("FAIL wrap_ffff: got %h@%h expected 0FFF@FFFF", obs_instr, obs_pc); end
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (obs_pc !== 16'h0000 || obs_instr !== 16'h1000) begin n_fail++; $display("FAIL wrap_0000: got %h@%h expected 1000@0000", obs_instr, obs_pc); end
  endtask

  task automatic test_random();
    logic st, br, inj;
    logic [15:0] tgt;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom_range(0, 65535));
      inj = !m_infl && ($urandom_range(0, 4) == 0);
      cycle(st, br, tgt, inj);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run();
    test_stall();
    test_branch();
    test_branch_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
